// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Groups the two requester handshakes and the single-port RAM bus of the
//   two-way RAM arbiter into one bundle.
//
//   Requester side : req0/1, rw0/1, addr0/1, din0/1   (into the arbiter)
//                    gnt0/1, done0/1, dout0/1         (out of the arbiter)
//   RAM side       : ram_cs, ram_rw, ram_addr, ram_din (out of the arbiter)
//                    ram_dout                          (into the arbiter)
//
//   slave  : the arbiter itself
//   master : the environment (requesters plus RAM model)
interface ram_arbiter_if #(
  parameter int addr_size = 10,
  parameter int data_size = 8
);
  logic                 req0;
  logic                 req1;
  logic                 rw0;
  logic                 rw1;
  logic [addr_size-1:0] addr0;
  logic [addr_size-1:0] addr1;
  logic [data_size-1:0] din0;
  logic [data_size-1:0] din1;

  logic                 gnt0;
  logic                 gnt1;
  logic                 done0;
  logic                 done1;
  logic [data_size-1:0] dout0;
  logic [data_size-1:0] dout1;

  logic                 ram_cs;
  logic                 ram_rw;
  logic [addr_size-1:0] ram_addr;
  logic [data_size-1:0] ram_din;
  logic [data_size-1:0] ram_dout;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, din0, din1, ram_dout,
    output gnt0, gnt1, done0, done1, dout0, dout1,
           ram_cs, ram_rw, ram_addr, ram_din
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, din0, din1, ram_dout,
    input  gnt0, gnt1, done0, done1, dout0, dout1,
           ram_cs, ram_rw, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Arbitrates two requesters onto one single-port RAM. Each transaction
//   takes three cycles: IDLE (pick winner, latch its command), ACCESS
//   (drive the RAM, grant pulse), RESP (capture read data), after which a
//   one-cycle done pulse appears while the FSM is back in IDLE and can
//   already start the next transaction.
//
//   Ports:
//     clk    : system clock, all state changes on the rising edge
//     rst_n  : synchronous active-low reset
//     bus    : ram_arbiter_if.slave, requester handshakes and RAM bus
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting; an eligible request is latched and wins the slot
//   ACCESS | ram_cs high, latched command on the RAM bus, gnt to winner
//   RESP   | RAM read data valid; captured into the winner's dout
module ram_arbiter #(
  parameter int addr_size = 10,
  parameter int data_size = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  // win_q: requester owning the current transaction (0 or 1)
  logic                 win_q;
  // last_grant: requester served most recently; resets to 1 so that
  // requester 0 wins the first contention
  logic                 last_grant;
  logic                 rw_q;
  logic [addr_size-1:0] addr_q;
  logic [data_size-1:0] din_q;

  logic                 done0_q;
  logic                 done1_q;
  logic [data_size-1:0] dout0_q;
  logic [data_size-1:0] dout1_q;

  logic                 elig0;
  logic                 elig1;
  logic                 take;
  logic                 pick;
  logic                 access;

  // A requester that is seeing its own done pulse is not eligible, even if
  // it still holds req high; this lets the other side in on back-to-back.
  always_comb begin
    elig0 = bus.req0 & ~done0_q;
    elig1 = bus.req1 & ~done1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = win_q;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          take      = 1'b1;
          state_nxt = ACCESS;
          if (elig0 && elig1) begin
            // round-robin: the side not served last wins
            pick = ~last_grant;
          end else begin
            pick = elig1;
          end
        end
      end
      ACCESS: state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch. Captured only on the IDLE sampling edge so later changes
  // on the requester inputs cannot disturb a transaction in flight. The
  // address and data keep their last values outside ACCESS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= 1'b0;
      rw_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (take) begin
      win_q  <= pick;
      rw_q   <= pick ? bus.rw1   : bus.rw0;
      addr_q <= pick ? bus.addr1 : bus.addr0;
      din_q  <= pick ? bus.din1  : bus.din0;
    end
  end

  // Completion. Reset clears everything, so a transaction caught in ACCESS
  // or RESP never reports done and never updates dout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      last_grant <= 1'b1;
    end else begin
      done0_q <= (state == RESP) && !win_q;
      done1_q <= (state == RESP) &&  win_q;
      if (state == RESP) begin
        last_grant <= win_q;
        if (!rw_q) begin
          if (win_q) begin
            dout1_q <= bus.ram_dout;
          end else begin
            dout0_q <= bus.ram_dout;
          end
        end
      end
    end
  end

  assign access = (state == ACCESS);

  assign bus.ram_cs   = access;
  assign bus.ram_rw   = access & rw_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;

  assign bus.gnt0  = access & ~win_q;
  assign bus.gnt1  = access &  win_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.dout0 = dout0_q;
  assign bus.dout1 = dout1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter: a small synchronous RAM model sits on
//   the RAM bus; requester inputs are driven 1 time unit after each rising
//   edge and outputs are checked at the same point.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ram_arbiter_if #(.addr_size(AW), .data_size(DW)) bus ();

  ram_arbiter #(.addr_size(AW), .data_size(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: write on cs&rw, read data one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_rw) begin
        mem[bus.ram_addr] <= bus.ram_din;
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.rw0   = 1'b0;
    bus.rw1   = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.din0  = '0;
    bus.din1  = '0;

    // reset state
    step();
    step();
    check("rst_gnt0",     32'(bus.gnt0),     0);
    check("rst_gnt1",     32'(bus.gnt1),     0);
    check("rst_done0",    32'(bus.done0),    0);
    check("rst_done1",    32'(bus.done1),    0);
    check("rst_dout0",    32'(bus.dout0),    0);
    check("rst_dout1",    32'(bus.dout1),    0);
    check("rst_ram_cs",   32'(bus.ram_cs),   0);
    check("rst_ram_rw",   32'(bus.ram_rw),   0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_din",  32'(bus.ram_din),  0);

    // req0 write addr 1 data 14, requested in the first cycle out of reset
    rst_n     = 1'b1;
    bus.req0  = 1'b1;
    bus.rw0   = 1'b1;
    bus.addr0 = 10'd1;
    bus.din0  = 8'd14;
    step();
    check("w0_gnt0",     32'(bus.gnt0),     1);
    check("w0_gnt1",     32'(bus.gnt1),     0);
    check("w0_cs",       32'(bus.ram_cs),   1);
    check("w0_rw",       32'(bus.ram_rw),   1);
    check("w0_addr",     32'(bus.ram_addr), 1);
    check("w0_din",      32'(bus.ram_din),  14);
    bus.req0 = 1'b0;
    step();
    check("w0_resp_cs",   32'(bus.ram_cs),   0);
    check("w0_resp_rw",   32'(bus.ram_rw),   0);
    check("w0_resp_gnt0", 32'(bus.gnt0),     0);
    check("w0_resp_addr", 32'(bus.ram_addr), 1);
    check("w0_resp_din",  32'(bus.ram_din),  14);
    check("w0_resp_done", 32'(bus.done0),    0);
    step();
    check("w0_done0", 32'(bus.done0), 1);
    check("w0_done1", 32'(bus.done1), 0);
    check("w0_dout0", 32'(bus.dout0), 0);
    step();
    check("w0_done0_off", 32'(bus.done0), 0);

    // req1 write addr 4 data 12, then req0 read addr 4 back-to-back
    bus.req1  = 1'b1;
    bus.rw1   = 1'b1;
    bus.addr1 = 10'd4;
    bus.din1  = 8'd12;
    step();
    check("w1_gnt1", 32'(bus.gnt1),     1);
    check("w1_gnt0", 32'(bus.gnt0),     0);
    check("w1_addr", 32'(bus.ram_addr), 4);
    check("w1_din",  32'(bus.ram_din),  12);
    bus.req1 = 1'b0;
    step();
    step();
    check("w1_done1", 32'(bus.done1), 1);
    check("w1_dout1", 32'(bus.dout1), 0);
    bus.req0  = 1'b1;
    bus.rw0   = 1'b0;
    bus.addr0 = 10'd4;
    step();
    check("r0_b2b_gnt0", 32'(bus.gnt0),   1);
    check("r0_b2b_rw",   32'(bus.ram_rw), 0);
    bus.req0 = 1'b0;
    step();
    step();
    check("r0_done0", 32'(bus.done0), 1);
    check("r0_dout0", 32'(bus.dout0), 12);
    check("r0_dout1", 32'(bus.dout1), 0);

    // both reading, held high after a fresh reset: order 0,1,0,1
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.rw0   = 1'b0;
    bus.rw1   = 1'b0;
    bus.addr0 = 10'd1;
    bus.addr1 = 10'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_gnt0", 32'(bus.gnt0), (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", 32'(bus.gnt1), (i % 2 == 1) ? 1 : 0);
      step();
      check("rr_resp_cs", 32'(bus.ram_cs), 0);
      step();
      check("rr_done0", 32'(bus.done0), (i % 2 == 0) ? 1 : 0);
      check("rr_done1", 32'(bus.done1), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) begin
        check("rr_dout0", 32'(bus.dout0), 14);
        check("rr_dout1_hold", 32'(bus.dout1), (i == 0) ? 0 : 12);
      end else begin
        check("rr_dout1", 32'(bus.dout1), 12);
        check("rr_dout0_hold", 32'(bus.dout0), 14);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    check("rr_idle_cs", 32'(bus.ram_cs), 0);

    // req1 alone with last_grant=1, dropping req during its done cycle
    bus.rw1   = 1'b0;
    bus.addr1 = 10'd1;
    for (int i = 0; i < 3; i++) begin
      bus.req1 = 1'b1;
      step();
      check("solo1_gnt1", 32'(bus.gnt1), 1);
      check("solo1_gnt0", 32'(bus.gnt0), 0);
      step();
      step();
      check("solo1_done1", 32'(bus.done1), 1);
      check("solo1_dout1", 32'(bus.dout1), 14);
      bus.req1 = 1'b0;
      step();
      check("solo1_gap_cs", 32'(bus.ram_cs), 0);
    end

    // reset during ACCESS of a req0 read aborts the transaction
    bus.req0  = 1'b1;
    bus.rw0   = 1'b0;
    bus.addr0 = 10'd1;
    step();
    check("abort_gnt0", 32'(bus.gnt0), 1);
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    step();
    check("abort_cs",    32'(bus.ram_cs), 0);
    check("abort_gnt0b", 32'(bus.gnt0),   0);
    check("abort_dout0", 32'(bus.dout0),  0);
    rst_n = 1'b1;
    step();
    check("abort_done0",  32'(bus.done0),  0);
    check("abort_dout0b", 32'(bus.dout0),  0);
    check("abort_cs_b",   32'(bus.ram_cs), 0);
    step();
    check("abort_done0b", 32'(bus.done0),  0);
    check("abort_idle",   32'(bus.ram_cs), 0);

    // address change during ACCESS does not disturb the transaction
    bus.req0  = 1'b1;
    bus.rw0   = 1'b0;
    bus.addr0 = 10'd1;
    step();
    check("hold_addr_acc", 32'(bus.ram_addr), 1);
    bus.addr0 = 10'd4;
    bus.req0  = 1'b0;
    step();
    check("hold_addr_resp", 32'(bus.ram_addr), 1);
    step();
    check("hold_done0", 32'(bus.done0), 1);
    check("hold_dout0", 32'(bus.dout0), 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
